// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead byte FIFO.
// The CPU pops on each rising edge of rd_req; sticky error flags are cleared by clr_err.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AW         = 3
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          uart_rx,
  input  logic          rd_req,
  input  logic          clr_err,
  output logic [7:0]    rdata,
  output logic          rx_valid,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          frame_err,
  output logic          rx_irq
);

  localparam int unsigned Div  = CLK_HZ / (BAUD * 16);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(Div - 1);
  localparam logic [AW:0]     Depth  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

  // Input synchronisers and rd_req edge detect
  logic rx_meta_q, rx_s_q, rd_meta_q, rd_s_q, rd_prev_q;
  logic pop;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rd_meta_q <= 1'b1;
      rd_s_q    <= 1'b1;
      rd_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rd_meta_q <= rd_req;
      rd_s_q    <= rd_meta_q;
      rd_prev_q <= rd_s_q;
    end
  end

  assign pop = rd_s_q & ~rd_prev_q;

  // Receiver state
  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      scnt_q, scnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tick, push, ferr_set;

  assign tick = (div_q == DivMax);

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    div_d    = tick ? '0 : div_q + 1'b1;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          scnt_d  = 4'd0;
          div_d   = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (scnt_q == 4'd7) begin
            // Still low at mid start bit: a real frame, otherwise a glitch
            if (!rx_s_q) begin
              state_d = StData;
              scnt_d  = 4'd0;
              bidx_d  = 3'd0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (scnt_q == 4'd15) begin
            shift_d[bidx_q] = rx_s_q;
            scnt_d          = 4'd0;
            if (bidx_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bidx_d = bidx_q + 1'b1;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (scnt_q == 4'd15) begin
            scnt_d = 4'd0;
            if (rx_s_q) begin
              push    = 1'b1;
              state_d = StIdle;
            end else begin
              ferr_set = 1'b1;
              state_d  = StWaitHi;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      StWaitHi: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      scnt_q  <= 4'd0;
      bidx_q  <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
    end
  end

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty, full, do_pop, do_push, ovr_set;
  logic          overrun_q, frame_err_q;

  assign empty   = (count_q == '0);
  assign full    = (count_q == Depth);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      overrun_q   <= ovr_set | (overrun_q & ~clr_err);
      frame_err_q <= ferr_set | (frame_err_q & ~clr_err);
    end
  end

  assign rdata     = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rx_valid  = ~empty;
  assign rx_irq    = ~empty;
  assign count     = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at a fast line rate (4 sysclk per tick, 64 per bit).
// Status is compared as {count, rdata, rx_valid, overrun, frame_err, rx_irq}.
module tb_uart_rx_fifo;

  localparam int unsigned ClkHz = 6_400_000;
  localparam int unsigned Baud  = 100_000;
  localparam int          Bit   = 64;

  logic       sysclk  = 1'b0;
  logic       reset   = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rd_req  = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       rx_valid;
  logic [3:0] count;
  logic       overrun;
  logic       frame_err;
  logic       rx_irq;
  logic [15:0] obs;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        send;
    logic [7:0]  data;
    logic [15:0] exp;
  } vec_t;

  vec_t       tbl [20];
  logic [7:0] heads [7];

  always #5 sysclk = ~sysclk;

  uart_rx_fifo #(
    .CLK_HZ    (ClkHz),
    .BAUD      (Baud),
    .FIFO_DEPTH(8),
    .AW        (3)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rd_req   (rd_req),
    .clr_err  (clr_err),
    .rdata    (rdata),
    .rx_valid (rx_valid),
    .count    (count),
    .overrun  (overrun),
    .frame_err(frame_err),
    .rx_irq   (rx_irq)
  );

  assign obs = {count, rdata, rx_valid, overrun, frame_err, rx_irq};

  function automatic logic [15:0] st(input logic [3:0] c, input logic [7:0] d,
                                     input logic o, input logic f);
    return {c, d, (c != 4'd0), o, f, (c != 4'd0)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v, input int extra_low);
    uart_rx = 1'b0;
    idle(Bit);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      idle(Bit);
    end
    uart_rx = stop_v;
    idle(Bit);
    if (!stop_v) idle(extra_low * Bit);
    uart_rx = 1'b1;
  endtask

  task automatic pop_pulse();
    rd_req = 1'b1;
    idle(3);
    rd_req = 1'b0;
    idle(4);
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, st(4'd1, 8'hA5, 1'b0, 1'b0)};
    tbl[1]  = '{1'b0, 8'h00, st(4'd0, 8'h00, 1'b0, 1'b0)};
    tbl[2]  = '{1'b1, 8'h00, st(4'd1, 8'h00, 1'b0, 1'b0)};
    tbl[3]  = '{1'b1, 8'h01, st(4'd2, 8'h00, 1'b0, 1'b0)};
    tbl[4]  = '{1'b1, 8'h02, st(4'd3, 8'h00, 1'b0, 1'b0)};
    tbl[5]  = '{1'b1, 8'h03, st(4'd4, 8'h00, 1'b0, 1'b0)};
    tbl[6]  = '{1'b1, 8'h04, st(4'd5, 8'h00, 1'b0, 1'b0)};
    tbl[7]  = '{1'b1, 8'h05, st(4'd6, 8'h00, 1'b0, 1'b0)};
    tbl[8]  = '{1'b1, 8'h06, st(4'd7, 8'h00, 1'b0, 1'b0)};
    tbl[9]  = '{1'b1, 8'h07, st(4'd8, 8'h00, 1'b0, 1'b0)};
    tbl[10] = '{1'b1, 8'h08, st(4'd8, 8'h00, 1'b1, 1'b0)};
    tbl[11] = '{1'b1, 8'h09, st(4'd8, 8'h00, 1'b1, 1'b0)};
    tbl[12] = '{1'b0, 8'h00, st(4'd7, 8'h01, 1'b1, 1'b0)};
    tbl[13] = '{1'b0, 8'h00, st(4'd6, 8'h02, 1'b1, 1'b0)};
    tbl[14] = '{1'b0, 8'h00, st(4'd5, 8'h03, 1'b1, 1'b0)};
    tbl[15] = '{1'b0, 8'h00, st(4'd4, 8'h04, 1'b1, 1'b0)};
    tbl[16] = '{1'b0, 8'h00, st(4'd3, 8'h05, 1'b1, 1'b0)};
    tbl[17] = '{1'b0, 8'h00, st(4'd2, 8'h06, 1'b1, 1'b0)};
    tbl[18] = '{1'b0, 8'h00, st(4'd1, 8'h07, 1'b1, 1'b0)};
    tbl[19] = '{1'b0, 8'h00, st(4'd0, 8'h00, 1'b1, 1'b0)};
    heads   = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hEE};

    idle(3);
    check("in_reset", obs, 16'h0000);
    reset = 1'b1;
    idle(4);
    check("post_reset", obs, 16'h0000);

    // Single byte, pop, then overrun fill and drain in order
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].send) send(tbl[i].data, 1'b1, 0);
      else pop_pulse();
      check($sformatf("vec%0d", i), obs, tbl[i].exp);
    end
    clr_pulse();
    check("clr_overrun", obs, st(4'd0, 8'h00, 1'b0, 1'b0));

    // Short low glitch must not start a frame
    uart_rx = 1'b0;
    idle(12);
    uart_rx = 1'b1;
    idle(2 * Bit);
    check("glitch", obs, st(4'd0, 8'h00, 1'b0, 1'b0));

    // Bad stop bit followed by a break, then a good frame
    send(8'h3C, 1'b0, 2);
    check("ferr_set", obs, st(4'd0, 8'h00, 1'b0, 1'b1));
    idle(Bit);
    send(8'h81, 1'b1, 0);
    check("rx_after_break", obs, st(4'd1, 8'h81, 1'b0, 1'b1));
    clr_pulse();
    check("clr_ferr", obs, st(4'd1, 8'h81, 1'b0, 1'b0));
    pop_pulse();
    check("drain_81", obs, st(4'd0, 8'h00, 1'b0, 1'b0));

    // Full FIFO with a pop landing on the same edge as the push of 8'hEE
    for (int k = 0; k < 8; k++) send(8'h10 + 8'(k), 1'b1, 0);
    check("fill", obs, st(4'd8, 8'h10, 1'b0, 1'b0));
    fork
      send(8'hEE, 1'b1, 0);
      begin
        idle(608);
        rd_req = 1'b1;
        idle(4);
        rd_req = 1'b0;
      end
    join
    check("full_push_pop", obs, st(4'd8, 8'h11, 1'b0, 1'b0));
    rd_req = 1'b1;
    idle(40);
    rd_req = 1'b0;
    idle(4);
    check("held_pop", obs, st(4'd7, 8'h12, 1'b0, 1'b0));
    for (int k = 0; k < 7; k++) begin
      check($sformatf("head%0d", k), obs, st(4'(7 - k), heads[k], 1'b0, 1'b0));
      pop_pulse();
    end
    check("drained", obs, st(4'd0, 8'h00, 1'b0, 1'b0));

    // Reset during bit 4 of a frame
    send(8'h77, 1'b1, 0);
    check("pre_reset_byte", obs, st(4'd1, 8'h77, 1'b0, 1'b0));
    uart_rx = 1'b0;
    idle(Bit);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (i < 2) ? 1'b1 : 1'b0;
      idle(Bit);
    end
    uart_rx = 1'b0;
    idle(Bit / 2);
    reset   = 1'b0;
    uart_rx = 1'b1;
    idle(2);
    check("mid_frame_reset", obs, 16'h0000);
    idle(6);
    reset = 1'b1;
    idle(Bit * 2);
    check("after_reset_idle", obs, 16'h0000);
    send(8'h5A, 1'b1, 0);
    check("rx_5a", obs, st(4'd1, 8'h5A, 1'b0, 1'b0));
    pop_pulse();
    check("drain_5a", obs, st(4'd0, 8'h00, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
